// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and widths for the MIPS memory-access stage
package mips_pkg;

   localparam int REG_W  = 5;
   localparam int WORD_W = 32;
   localparam int LANES  = WORD_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory req/ack bus between the ME stage and memory
interface mem_access_if #(
   parameter int DMEM_AW = 30
);

   logic               DmemReq;
   logic               DmemWe;
   logic [DMEM_AW-1:0] DmemAddr;
   logic [31:0]        DmemWrDat;
   logic [3:0]         DmemBe;
   logic               DmemAck;
   logic [31:0]        DmemRdDat;

   modport master (
      output DmemReq, DmemWe, DmemAddr, DmemWrDat, DmemBe,
      input  DmemAck, DmemRdDat
   );

   modport slave (
      input  DmemReq, DmemWe, DmemAddr, DmemWrDat, DmemBe,
      output DmemAck, DmemRdDat
   );

endinterface

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - byte load extract/sign-extend and byte store replicate (MEM_ACCESS_BYTE_EN)
`ifdef MEM_ACCESS_BYTE_EN
module mem_byte_lane
   import mips_pkg::*;
(
   input  logic [1:0]        byte_sel,
   input  logic              load_byte,
   input  logic              store_byte,
   input  logic [WORD_W-1:0] rd_word,
   input  logic [WORD_W-1:0] wr_word,
   output logic [WORD_W-1:0] ld_data,
   output logic [WORD_W-1:0] st_data,
   output logic [LANES-1:0]  be
);

   logic [7:0] rd_byte;

   // Pick the addressed lane; stores put the byte on every lane and let be select it
   always_comb begin
      rd_byte = rd_word[{byte_sel, 3'b000} +: 8];
      ld_data = load_byte ? {{(WORD_W-8){rd_byte[7]}}, rd_byte} : rd_word;
      st_data = store_byte ? {LANES{wr_word[7:0]}} : wr_word;
      be      = store_byte ? (LANES'(1) << byte_sel) : {LANES{1'b1}};
   end

endmodule
`endif

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MIPS memory-access stage: dmem req/ack, load buffer, ME register; option MEM_ACCESS_BYTE_EN
module mem_access
   import mips_pkg::*;
#(
   parameter int DMEM_AW = 30
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] Result_EX,
   input  logic [WORD_W-1:0] WrDat_EX,
   input  logic [REG_W-1:0]  WriteReg_EX,
   input  logic              RegWrite_EX,
   input  logic              MemToReg_EX,
   input  logic              MemWrite_EX,
   input  logic              LoadB_EX,
   input  logic              StoreB_EX,
   input  logic              InstrVal_EX,
   input  logic              AnyStall,
   output logic              MemStall_MEM1,
   output logic [WORD_W-1:0] ResultRdDat_ME,
   output logic [REG_W-1:0]  WriteReg_ME,
   output logic              RegWrite_ME,
   output logic              InstrVal_ME,
   mem_access_if.master      dmem
);

   mem_state_e        state_q, state_d;
   logic [WORD_W-1:0] ldbuf_q, ldbuf_d;
   logic [WORD_W-1:0] result_q, result_d;
   logic [REG_W-1:0]  wreg_q, wreg_d;
   logic              regwr_q, regwr_d;
   logic              ival_q, ival_d;

   logic              mem_op;
   logic [WORD_W-1:0] load_data;
   logic [WORD_W-1:0] store_data;
   logic [LANES-1:0]  byte_en;

   assign mem_op = InstrVal_EX & (MemToReg_EX | MemWrite_EX);

`ifdef MEM_ACCESS_BYTE_EN
   mem_byte_lane u_lane (
      .byte_sel   (Result_EX[1:0]),
      .load_byte  (LoadB_EX),
      .store_byte (StoreB_EX),
      .rd_word    (ldbuf_q),
      .wr_word    (WrDat_EX),
      .ld_data    (load_data),
      .st_data    (store_data),
      .be         (byte_en)
   );
`else
   logic unused_byte_ctl;
   assign unused_byte_ctl = LoadB_EX ^ StoreB_EX ^ (^Result_EX[1:0]);
   assign load_data  = ldbuf_q;
   assign store_data = WrDat_EX;
   assign byte_en    = {LANES{1'b1}};
`endif

   // Address and data come straight from the EX register, which the stall holds steady
   assign dmem.DmemAddr  = Result_EX[DMEM_AW+1:2];
   assign dmem.DmemWrDat = store_data;
   assign dmem.DmemBe    = byte_en;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state: one request per EX memory op, then wait in DONE until the pipe moves
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mem_op) state_d = REQ;
         REQ:     if (dmem.DmemAck) state_d = DONE;
         DONE:    if (!AnyStall) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs; stall never looks at AnyStall so the external OR cannot loop
   always_comb begin
      MemStall_MEM1 = 1'b0;
      dmem.DmemReq  = 1'b0;
      dmem.DmemWe   = 1'b0;
      case (state_q)
         IDLE:    MemStall_MEM1 = mem_op;
         REQ: begin
            MemStall_MEM1 = 1'b1;
            dmem.DmemReq  = 1'b1;
            dmem.DmemWe   = MemWrite_EX;
         end
         default: ;
      endcase
   end

   // Load buffer captures read data only on the ack that ends REQ
   always_comb begin
      ldbuf_d = ldbuf_q;
      if (state_q == REQ && dmem.DmemAck) ldbuf_d = dmem.DmemRdDat;
   end

   // ME register: take EX when the pipe advances, otherwise insert a bubble
   always_comb begin
      result_d = '0;
      wreg_d   = '0;
      regwr_d  = 1'b0;
      ival_d   = 1'b0;
      if (!AnyStall) begin
         result_d = MemToReg_EX ? load_data : Result_EX;
         wreg_d   = WriteReg_EX;
         regwr_d  = RegWrite_EX & InstrVal_EX;
         ival_d   = InstrVal_EX;
      end
   end

   // Data-path flops
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ldbuf_q  <= '0;
         result_q <= '0;
         wreg_q   <= '0;
         regwr_q  <= 1'b0;
         ival_q   <= 1'b0;
      end else begin
         ldbuf_q  <= ldbuf_d;
         result_q <= result_d;
         wreg_q   <= wreg_d;
         regwr_q  <= regwr_d;
         ival_q   <= ival_d;
      end
   end

   assign ResultRdDat_ME = result_q;
   assign WriteReg_ME    = wreg_q;
   assign RegWrite_ME    = regwr_q;
   assign InstrVal_ME    = ival_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] Result_EX, WrDat_EX;
   logic [4:0]  WriteReg_EX;
   logic        RegWrite_EX, MemToReg_EX, MemWrite_EX, LoadB_EX, StoreB_EX, InstrVal_EX;
   logic        AnyStall, ext_stall;
   logic        MemStall_MEM1;
   logic [31:0] ResultRdDat_ME;
   logic [4:0]  WriteReg_ME;
   logic        RegWrite_ME, InstrVal_ME;

   int checks = 0;
   int errors = 0;

   mem_access_if #(.DMEM_AW(30)) bus ();

   always #5 clk = ~clk;

   assign AnyStall = MemStall_MEM1 | ext_stall;

   mem_access #(.DMEM_AW(30)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .Result_EX      (Result_EX),
      .WrDat_EX       (WrDat_EX),
      .WriteReg_EX    (WriteReg_EX),
      .RegWrite_EX    (RegWrite_EX),
      .MemToReg_EX    (MemToReg_EX),
      .MemWrite_EX    (MemWrite_EX),
      .LoadB_EX       (LoadB_EX),
      .StoreB_EX      (StoreB_EX),
      .InstrVal_EX    (InstrVal_EX),
      .AnyStall       (AnyStall),
      .MemStall_MEM1  (MemStall_MEM1),
      .ResultRdDat_ME (ResultRdDat_ME),
      .WriteReg_ME    (WriteReg_ME),
      .RegWrite_ME    (RegWrite_ME),
      .InstrVal_ME    (InstrVal_ME),
      .dmem           (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic set_ex(input logic [31:0] res, input logic [31:0] wd, input logic [4:0] wr,
                         input logic rw, input logic m2r, input logic mw,
                         input logic lb, input logic sb, input logic iv);
      Result_EX   = res;
      WrDat_EX    = wd;
      WriteReg_EX = wr;
      RegWrite_EX = rw;
      MemToReg_EX = m2r;
      MemWrite_EX = mw;
      LoadB_EX    = lb;
      StoreB_EX   = sb;
      InstrVal_EX = iv;
   endtask

   task automatic set_nop();
      set_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Byte-flagged load with ack in the first REQ cycle
   task automatic do_byte_load(input string tag, input logic [31:0] addr,
                               input logic [31:0] rd, input logic [31:0] exp);
      adv();
      set_ex(addr, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      samp();
      check({tag, "_stall_idle"}, 32'(MemStall_MEM1), 32'd1);
      adv();
      bus.DmemAck   = 1'b1;
      bus.DmemRdDat = rd;
      samp();
      check({tag, "_req"}, 32'(bus.DmemReq), 32'd1);
      check({tag, "_addr"}, 32'(bus.DmemAddr), 32'(addr >> 2));
      adv();
      bus.DmemAck = 1'b0;
      samp();
      check({tag, "_stall_done"}, 32'(MemStall_MEM1), 32'd0);
      adv();
      set_nop();
      samp();
      check({tag, "_data"}, ResultRdDat_ME, exp);
      check({tag, "_wreg"}, 32'(WriteReg_ME), 32'd9);
   endtask

   initial begin
      rst_n         = 1'b0;
      ext_stall     = 1'b0;
      bus.DmemAck   = 1'b1;
      bus.DmemRdDat = 32'hFFFF_FFFF;
      set_nop();

      // Reset, ack held high throughout
      adv();
      adv();
      samp();
      check("rst_req", 32'(bus.DmemReq), 32'd0);
      check("rst_we", 32'(bus.DmemWe), 32'd0);
      check("rst_stall", 32'(MemStall_MEM1), 32'd0);
      check("rst_result", ResultRdDat_ME, 32'd0);
      check("rst_wreg", 32'(WriteReg_ME), 32'd0);
      check("rst_regwr", 32'(RegWrite_ME), 32'd0);
      check("rst_ival", 32'(InstrVal_ME), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));
      check("rst_ldbuf", dut.ldbuf_q, 32'd0);

      // Word load, ack in the second REQ cycle
      adv();
      rst_n       = 1'b1;
      bus.DmemAck = 1'b0;
      set_ex(32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      samp();
      check("wl_stall1", 32'(MemStall_MEM1), 32'd1);
      check("wl_noreq_idle", 32'(bus.DmemReq), 32'd0);
      check("wl_addr", 32'(bus.DmemAddr), 32'h40);
      adv();
      samp();
      check("wl_stall2", 32'(MemStall_MEM1), 32'd1);
      check("wl_req", 32'(bus.DmemReq), 32'd1);
      check("wl_we", 32'(bus.DmemWe), 32'd0);
      check("wl_be", 32'(bus.DmemBe), 32'hF);
      adv();
      bus.DmemAck   = 1'b1;
      bus.DmemRdDat = 32'hDEAD_BEEF;
      samp();
      check("wl_stall3", 32'(MemStall_MEM1), 32'd1);
      check("wl_req_held", 32'(bus.DmemReq), 32'd1);
      adv();
      bus.DmemAck   = 1'b0;
      bus.DmemRdDat = 32'h0;
      samp();
      check("wl_done_stall", 32'(MemStall_MEM1), 32'd0);
      check("wl_done_req", 32'(bus.DmemReq), 32'd0);
      check("wl_done_bubble", 32'(InstrVal_ME), 32'd0);
      adv();
      set_nop();
      samp();
      check("wl_result", ResultRdDat_ME, 32'hDEAD_BEEF);
      check("wl_wreg", 32'(WriteReg_ME), 32'd5);
      check("wl_regwr", 32'(RegWrite_ME), 32'd1);
      check("wl_ival", 32'(InstrVal_ME), 32'd1);

      // Byte-flagged loads: sign-extended lane with the option, full word without
`ifdef MEM_ACCESS_BYTE_EN
      do_byte_load("bl103", 32'h103, 32'h8011_2233, 32'hFFFF_FF80);
      do_byte_load("bl100", 32'h100, 32'h8011_2233, 32'h0000_0033);
`else
      do_byte_load("bl103", 32'h103, 32'h8011_2233, 32'h8011_2233);
      do_byte_load("bl100", 32'h100, 32'h8011_2233, 32'h8011_2233);
`endif

      // Byte-flagged store at 0x102
      adv();
      set_ex(32'h102, 32'h0000_00A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      samp();
      check("st_stall1", 32'(MemStall_MEM1), 32'd1);
      adv();
      bus.DmemAck   = 1'b1;
      bus.DmemRdDat = 32'h5555_5555;
      samp();
      check("st_req", 32'(bus.DmemReq), 32'd1);
      check("st_we", 32'(bus.DmemWe), 32'd1);
      check("st_addr", 32'(bus.DmemAddr), 32'h40);
`ifdef MEM_ACCESS_BYTE_EN
      check("st_be", 32'(bus.DmemBe), 32'h4);
      check("st_wrdat", bus.DmemWrDat, 32'hA5A5_A5A5);
`else
      check("st_be", 32'(bus.DmemBe), 32'hF);
      check("st_wrdat", bus.DmemWrDat, 32'h0000_00A5);
`endif
      adv();
      bus.DmemAck = 1'b0;
      samp();
      check("st_done_we", 32'(bus.DmemWe), 32'd0);
      adv();
      set_nop();
      samp();
      check("st_regwr", 32'(RegWrite_ME), 32'd0);
      check("st_ival", 32'(InstrVal_ME), 32'd1);
      check("st_result", ResultRdDat_ME, 32'h102);

      // ALU op held by an external stall for two cycles
      adv();
      set_ex(32'h7, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      ext_stall = 1'b1;
      samp();
      check("alu_stall", 32'(MemStall_MEM1), 32'd0);
      check("alu_noreq1", 32'(bus.DmemReq), 32'd0);
      adv();
      samp();
      check("alu_bubble1", 32'(InstrVal_ME), 32'd0);
      check("alu_bubble1_rw", 32'(RegWrite_ME), 32'd0);
      adv();
      ext_stall = 1'b0;
      samp();
      check("alu_bubble2", 32'(InstrVal_ME), 32'd0);
      check("alu_noreq2", 32'(bus.DmemReq), 32'd0);
      adv();
      set_nop();
      samp();
      check("alu_result", ResultRdDat_ME, 32'h7);
      check("alu_wreg", 32'(WriteReg_ME), 32'd3);
      check("alu_regwr", 32'(RegWrite_ME), 32'd1);
      check("alu_ival", 32'(InstrVal_ME), 32'd1);
      adv();
      samp();
      check("alu_once", 32'(InstrVal_ME), 32'd0);

      // Reset while a request is outstanding, ack arrives one cycle late
      adv();
      set_ex(32'h200, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      samp();
      check("rr_stall", 32'(MemStall_MEM1), 32'd1);
      adv();
      rst_n = 1'b0;
      samp();
      check("rr_req", 32'(bus.DmemReq), 32'd1);
      adv();
      rst_n         = 1'b1;
      set_nop();
      bus.DmemAck   = 1'b1;
      bus.DmemRdDat = 32'h1234_5678;
      samp();
      check("rr_req_dropped", 32'(bus.DmemReq), 32'd0);
      check("rr_state", 32'(dut.state_q), 32'(IDLE));
      check("rr_regwr", 32'(RegWrite_ME), 32'd0);
      adv();
      bus.DmemAck = 1'b0;
      samp();
      check("rr_late_ack_ldbuf", dut.ldbuf_q, 32'd0);
      check("rr_regwr2", 32'(RegWrite_ME), 32'd0);
      check("rr_ival2", 32'(InstrVal_ME), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
